// File: rtl/br_ram_init_checker.sv
// Read-side RAM checker: sweeps every address once after start and compares each
// returned word against a captured value, reporting mismatches and protocol faults.
module br_ram_init_checker #(
    parameter int Depth       = 2,
    parameter int Width       = 1,
    parameter int ReadLatency = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [Width-1:0]           expected_value,
    output logic                       busy,
    output logic                       done,
    output logic                       rd_addr_valid,
    output logic [$clog2(Depth)-1:0]   rd_addr,
    input  logic                       rd_data_valid,
    input  logic [Width-1:0]           rd_data,
    output logic                       error,
    output logic [$clog2(Depth+1)-1:0] error_count,
    output logic                       first_error_valid,
    output logic [$clog2(Depth)-1:0]   first_error_addr,
    output logic                       protocol_error
);

    localparam int unsigned AddressWidth = $clog2(Depth);
    localparam int unsigned CountWidth   = $clog2(Depth + 1);
    localparam int unsigned PipeWidth    = ReadLatency * AddressWidth;

    localparam logic [AddressWidth-1:0] LastAddr = AddressWidth'(Depth - 1);
    localparam logic [CountWidth-1:0]   MaxCount = CountWidth'(Depth);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    logic [1:0]              state, state_d;
    logic [Width-1:0]        exp_q, exp_d;
    logic                    busy_d, done_d, rd_addr_valid_d;
    logic [AddressWidth-1:0] rd_addr_d;
    logic                    error_d, first_error_valid_d, protocol_error_d;
    logic [CountWidth-1:0]   error_count_d;
    logic [AddressWidth-1:0] first_error_addr_d;

    logic [ReadLatency-1:0]  pipe_valid;
    logic [PipeWidth-1:0]    pipe_addr;
    logic                    due;
    logic [AddressWidth-1:0] due_addr;
    logic                    mismatch;

    // The oldest pipeline slot is the response the RAM owes us this cycle
    assign due      = pipe_valid[ReadLatency-1];
    assign due_addr = pipe_addr[PipeWidth-1 -: AddressWidth];
    assign mismatch = due && (!rd_data_valid || (rd_data != exp_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_valid <= '0;
            pipe_addr  <= '0;
        end else begin
            pipe_valid <= ReadLatency'({pipe_valid, rd_addr_valid});
            pipe_addr  <= PipeWidth'({pipe_addr, rd_addr});
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            exp_q             <= '0;
            busy              <= 1'b0;
            done              <= 1'b0;
            rd_addr_valid     <= 1'b0;
            rd_addr           <= '0;
            error             <= 1'b0;
            error_count       <= '0;
            first_error_valid <= 1'b0;
            first_error_addr  <= '0;
            protocol_error    <= 1'b0;
        end else begin
            state             <= state_d;
            exp_q             <= exp_d;
            busy              <= busy_d;
            done              <= done_d;
            rd_addr_valid     <= rd_addr_valid_d;
            rd_addr           <= rd_addr_d;
            error             <= error_d;
            error_count       <= error_count_d;
            first_error_valid <= first_error_valid_d;
            first_error_addr  <= first_error_addr_d;
            protocol_error    <= protocol_error_d;
        end
    end

    always_comb begin
        state_d             = state;
        exp_d               = exp_q;
        busy_d              = busy;
        done_d              = 1'b0;
        rd_addr_valid_d     = rd_addr_valid;
        rd_addr_d           = rd_addr;
        error_d             = error;
        error_count_d       = error_count;
        first_error_valid_d = first_error_valid;
        first_error_addr_d  = first_error_addr;
        protocol_error_d    = protocol_error;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d             = ISSUE;
                    exp_d               = expected_value;
                    busy_d              = 1'b1;
                    rd_addr_valid_d     = 1'b1;
                    rd_addr_d           = '0;
                    error_d             = 1'b0;
                    error_count_d       = '0;
                    first_error_valid_d = 1'b0;
                    first_error_addr_d  = '0;
                    protocol_error_d    = 1'b0;
                end
            end
            ISSUE: begin
                if (rd_addr == LastAddr) begin
                    state_d         = DRAIN;
                    rd_addr_valid_d = 1'b0;
                    rd_addr_d       = '0;
                end else begin
                    rd_addr_d = AddressWidth'(rd_addr + 1'b1);
                end
            end
            DRAIN: begin
                if (due && (due_addr == LastAddr)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Fault detection runs every cycle, including IDLE, and wins over a start clear
        if (rd_data_valid != due) begin
            protocol_error_d = 1'b1;
        end
        if (mismatch) begin
            error_d = 1'b1;
            if (error_count < MaxCount) begin
                error_count_d = CountWidth'(error_count + 1'b1);
            end
            if (!first_error_valid) begin
                first_error_valid_d = 1'b1;
                first_error_addr_d  = due_addr;
            end
        end
    end

endmodule

// File: tb/tb_br_ram_init_checker.sv
// Directed bench for br_ram_init_checker: two instances (read latency 1 and 3)
// against a behavioural RAM with per-entry response suppression.
module tb_br_ram_init_checker;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       sel = 1'b0;
    logic       inj = 1'b0;
    logic [7:0] expected_value = 8'h00;
    logic [7:0] mem [DEPTH];
    logic [DEPTH-1:0] sup;

    logic       busy_a, done_a, rav_a, rdv_a, err_a, fev_a, prot_a;
    logic [1:0] rad_a, fea_a;
    logic [2:0] cnt_a;
    logic [7:0] rdd_a;
    logic       busy_b, done_b, rav_b, rdv_b, err_b, fev_b, prot_b;
    logic [1:0] rad_b, fea_b;
    logic [2:0] cnt_b;
    logic [7:0] rdd_b;

    logic       va_q;
    logic [7:0] da_q;
    logic       vb_q [3];
    logic [1:0] ab_q [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    br_ram_init_checker #(.Depth(DEPTH), .Width(8), .ReadLatency(1)) dut_a (
        .clk(clk), .rst(rst), .start(start && !sel), .expected_value(expected_value),
        .busy(busy_a), .done(done_a), .rd_addr_valid(rav_a), .rd_addr(rad_a),
        .rd_data_valid(rdv_a), .rd_data(rdd_a), .error(err_a), .error_count(cnt_a),
        .first_error_valid(fev_a), .first_error_addr(fea_a), .protocol_error(prot_a)
    );

    br_ram_init_checker #(.Depth(DEPTH), .Width(8), .ReadLatency(3)) dut_b (
        .clk(clk), .rst(rst), .start(start && sel), .expected_value(expected_value),
        .busy(busy_b), .done(done_b), .rd_addr_valid(rav_b), .rd_addr(rad_b),
        .rd_data_valid(rdv_b), .rd_data(rdd_b), .error(err_b), .error_count(cnt_b),
        .first_error_valid(fev_b), .first_error_addr(fea_b), .protocol_error(prot_b)
    );

    // Behavioural RAM read ports; sup[] drops the response for chosen entries
    always @(posedge clk) begin
        va_q     <= rav_a && !sup[rad_a];
        da_q     <= mem[rad_a];
        vb_q[0]  <= rav_b && !sup[rad_b];
        ab_q[0]  <= rad_b;
        vb_q[1]  <= vb_q[0];
        ab_q[1]  <= ab_q[0];
        vb_q[2]  <= vb_q[1];
        ab_q[2]  <= ab_q[1];
    end

    assign rdv_a = va_q | (inj && !sel);
    assign rdd_a = da_q;
    assign rdv_b = vb_q[2] | (inj && sel);
    assign rdd_b = mem[ab_q[2]];

    logic       busy_s, done_s, rav_s, err_s, fev_s, prot_s;
    logic [1:0] rad_s, fea_s;
    logic [2:0] cnt_s;
    assign busy_s = sel ? busy_b : busy_a;
    assign done_s = sel ? done_b : done_a;
    assign rav_s  = sel ? rav_b  : rav_a;
    assign rad_s  = sel ? rad_b  : rad_a;
    assign err_s  = sel ? err_b  : err_a;
    assign cnt_s  = sel ? cnt_b  : cnt_a;
    assign fev_s  = sel ? fev_b  : fev_a;
    assign fea_s  = sel ? fea_b  : fea_a;
    assign prot_s = sel ? prot_b : prot_a;

    typedef struct {
        logic        sel;
        logic [31:0] mem;
        logic [7:0]  expv;
        logic [3:0]  sup;
        int          cnt;
        logic        fev;
        int          fea;
        logic        prot;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_mem(input logic [31:0] pattern, input logic [3:0] s);
        for (int i = 0; i < DEPTH; i++) mem[i] = pattern[8*i +: 8];
        sup = s;
    endtask

    task automatic run_check(input logic [7:0] expv, input bit started, input bit disturb,
                             input bit chain, input logic [7:0] chain_expv,
                             output int done_cycle, output int busy_cycles,
                             output bit addr_ok, output bit inv_ok);
        done_cycle  = -1;
        busy_cycles = 0;
        addr_ok     = 1'b1;
        inv_ok      = 1'b1;
        if (!started) begin
            @(negedge clk);
            expected_value = expv;
            start = 1'b1;
        end
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) start = 1'b0;
            if (disturb && n == 2) begin
                start = 1'b1;
                expected_value = 8'h00;
            end
            if (disturb && n == 3) start = 1'b0;
            if (busy_s) busy_cycles++;
            if (rav_s != (n <= DEPTH)) addr_ok = 1'b0;
            else if (rav_s && (rad_s != 2'(n - 1))) addr_ok = 1'b0;
            if ((rav_s && !busy_s) || (done_s && busy_s) || (err_s != (cnt_s != 0))) inv_ok = 1'b0;
            if (done_s) begin
                done_cycle = n;
                if (chain) begin
                    start = 1'b1;
                    expected_value = chain_expv;
                end
                break;
            end
        end
    endtask

    task automatic check_run(input string tag, input int rl, input int done_cycle,
                             input int busy_cycles, input bit addr_ok, input bit inv_ok);
        chk({tag, " done_cycle"}, done_cycle, DEPTH + rl + 1);
        chk({tag, " busy_cycles"}, busy_cycles, DEPTH + rl);
        chk({tag, " addr_seq"}, int'(addr_ok), 1);
        chk({tag, " invariants"}, int'(inv_ok), 1);
    endtask

    task automatic check_results(input string tag, input int cnt, input logic fev,
                                 input int fea, input logic prot);
        chk({tag, " error"}, int'(err_s), int'(cnt != 0));
        chk({tag, " error_count"}, int'(cnt_s), cnt);
        chk({tag, " first_error_valid"}, int'(fev_s), int'(fev));
        if (fev) chk({tag, " first_error_addr"}, int'(fea_s), fea);
        chk({tag, " protocol_error"}, int'(prot_s), int'(prot));
    endtask

    initial begin
        vec_t vecs [6];
        int   dc, bc;
        bit   aok, iok;
        string tag;

        vecs[0] = '{1'b0, 32'hA5A5A5A5, 8'hA5, 4'b0000, 0, 1'b0, 0, 1'b0};
        vecs[1] = '{1'b0, 32'h0000A5A5, 8'hA5, 4'b0000, 2, 1'b1, 2, 1'b0};
        vecs[2] = '{1'b1, 32'hA5A5A5A5, 8'hA5, 4'b0010, 1, 1'b1, 1, 1'b1};
        vecs[3] = '{1'b0, 32'h5A000000, 8'h00, 4'b0000, 1, 1'b1, 3, 1'b0};
        vecs[4] = '{1'b0, 32'h01020304, 8'hFF, 4'b0000, 4, 1'b1, 0, 1'b0};
        vecs[5] = '{1'b1, 32'hA5A5A5A5, 8'hA5, 4'b1111, 4, 1'b1, 0, 1'b1};

        load_mem(32'hA5A5A5A5, 4'b0000);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            tag = $sformatf("reset%0d", s);
            chk({tag, " busy"}, int'(busy_s), 0);
            chk({tag, " done"}, int'(done_s), 0);
            chk({tag, " rd_addr_valid"}, int'(rav_s), 0);
            check_results(tag, 0, 1'b0, 0, 1'b0);
        end

        for (int i = 0; i < 6; i++) begin
            sel = vecs[i].sel;
            load_mem(vecs[i].mem, vecs[i].sup);
            run_check(vecs[i].expv, 1'b0, 1'b0, 1'b0, 8'h00, dc, bc, aok, iok);
            tag = $sformatf("vec%0d", i);
            check_run(tag, vecs[i].sel ? 3 : 1, dc, bc, aok, iok);
            check_results(tag, vecs[i].cnt, vecs[i].fev, vecs[i].fea, vecs[i].prot);
        end

        // start while busy plus a mid-check change of expected_value
        sel = 1'b0;
        load_mem(32'hA5A5A5A5, 4'b0000);
        run_check(8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, dc, bc, aok, iok);
        check_run("busy_start", 1, dc, bc, aok, iok);
        check_results("busy_start", 0, 1'b0, 0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("busy_start no_restart", int'(busy_s), 0);

        // rd_data_valid while idle
        @(negedge clk);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        chk("idle_resp protocol_error", int'(prot_s), 1);
        chk("idle_resp error_count", int'(cnt_s), 0);

        // Reset in the middle of a failing sweep
        load_mem(32'h00000000, 4'b0000);
        @(negedge clk);
        expected_value = 8'hA5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_reset pre count", int'(cnt_s), 1);
        rst = 1'b1;
        #1;
        chk("mid_reset busy", int'(busy_s), 0);
        chk("mid_reset rd_addr_valid", int'(rav_s), 0);
        chk("mid_reset done", int'(done_s), 0);
        check_results("mid_reset", 0, 1'b0, 0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        load_mem(32'hA5A5A5A5, 4'b0000);
        run_check(8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, dc, bc, aok, iok);
        check_run("post_reset", 1, dc, bc, aok, iok);
        check_results("post_reset", 0, 1'b0, 0, 1'b0);

        // Back-to-back: second start issued in the done cycle of the first
        load_mem(32'h00000000, 4'b0000);
        run_check(8'hA5, 1'b0, 1'b0, 1'b1, 8'h00, dc, bc, aok, iok);
        check_run("b2b_first", 1, dc, bc, aok, iok);
        check_results("b2b_first", 4, 1'b1, 0, 1'b0);
        run_check(8'h00, 1'b1, 1'b0, 1'b0, 8'h00, dc, bc, aok, iok);
        check_run("b2b_second", 1, dc, bc, aok, iok);
        check_results("b2b_second", 0, 1'b0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/br_ram_init_checker.md
Name: br_ram_init_checker

Overview:
- Read-side counterpart of the RAM initializer.
- On `start`, it sweeps the RAM read port over every address from 0 to Depth-1.
- It compares each returned word against a captured expected value and reports the mismatch count, first failing address and read-protocol violations.
- It sits beside the initializer on the RAM read port and is used for post-init self-check and BIST-style scrub of flop/SRAM arrays.

Parameters:
- Depth, 2, number of RAM entries; must be >= 2.
- Width, 1, RAM word width in bits; must be >= 1.
- ReadLatency, 1, fixed cycles from rd_addr_valid to rd_data_valid; must be >= 1.
- AddressWidth, $clog2(Depth), localparam.
- CountWidth, $clog2(Depth+1), localparam.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  begin check; accepted only when busy=0.
- expected_value  input  Width  value every entry must hold; sampled on accepted start.
- busy  output  1  check in progress.
- done  output  1  single-cycle pulse at completion.
- rd_addr_valid  output  1  read request valid.
- rd_addr  output  AddressWidth  read request address.
- rd_data_valid  input  1  read response valid.
- rd_data  input  Width  read response data.
- error  output  1  sticky; at least one mismatch in the current or last check.
- error_count  output  CountWidth  number of mismatching entries.
- first_error_valid  output  1  first_error_addr holds a valid address.
- first_error_addr  output  AddressWidth  address of the first mismatch.
- protocol_error  output  1  sticky; a response arrived when none was due, or a due response was missing.

Behaviour:
- Reset (async assert) drives every output and all internal state to 0. FSM is forced to IDLE.
- FSM states:
  - IDLE: start=1 goes to ISSUE.
  - ISSUE: after the Depth-th request, goes to DRAIN.
  - DRAIN: after the last due response slot, goes to IDLE.
- Start acceptance (start=1 in IDLE):
  - Captures expected_value into an internal register. Later changes to the input are ignored.
  - Clears error, error_count, first_error_valid, first_error_addr and protocol_error.
  - busy=1 from the next cycle.
- start while busy=1: ignored, with no effect on any state.
- Issue timing: start accepted at cycle 0 → rd_addr_valid=1 at cycles 1..Depth, with rd_addr = 0,1,…,Depth-1. Exactly one request per cycle, no gaps, no backpressure.
- Address counter: no wrap beyond Depth-1. rd_addr returns to 0 when rd_addr_valid=0.
- Response tracking:
  - An internal ReadLatency-deep pipeline carries (valid, addr) of each request.
  - The slot emerging at cycle t is "due"; its addr is the expected response address.
- Compare (evaluated every cycle with rd_data_valid=1 and a due slot):
  - Equality against the captured value, full Width.
  - On mismatch: error_count+1 (cannot exceed Depth), error<=1.
  - If first_error_valid=0 on a mismatch: first_error_addr<=slot addr and first_error_valid<=1.
- Protocol errors, checked every cycle:
  - rd_data_valid=1 with no due slot → protocol_error<=1, rd_data ignored.
  - Due slot with rd_data_valid=0 → protocol_error<=1, and that entry is counted as a mismatch.
  - rd_data_valid while in IDLE is also a protocol error.
- Completion:
  - Last due slot at cycle Depth+ReadLatency.
  - At cycle Depth+ReadLatency+1: done=1 for one cycle, busy=0, FSM in IDLE.
  - busy is high for exactly Depth+ReadLatency cycles.
- Results: error, error_count, first_error_*, protocol_error hold until the next accepted start or reset.
- Back-to-back checks: start may be accepted in the same cycle done=1, since FSM is IDLE then. The next check's busy follows at the next cycle.
- Reset mid-check: async clear to IDLE with all outputs 0. Responses in flight after reset release count as protocol errors only if rd_data_valid arrives while in IDLE.
- Invariants:
  - rd_addr_valid implies busy.
  - done implies !busy.
  - error == (error_count != 0).

Test Plan:
- Depth=4, Width=8, ReadLatency=1, RAM all 0xA5, expected_value=0xA5, start at cycle 0 → reads addr 0..3 at cycles 1..4; done at cycle 6; error=0, error_count=0, protocol_error=0.
- Same setup with entries 2 and 3 = 0x00 → error=1, error_count=2, first_error_valid=1, first_error_addr=2.
- ReadLatency=3, Depth=4, response for addr 1 suppressed → protocol_error=1, error_count=1, first_error_addr=1; done at cycle 8.
- start pulsed at cycle 2 while busy, and expected_value changed mid-check → no restart, done still at the original cycle, compare uses the value captured at cycle 0.
- rst asserted at cycle 3 of a check, then released → busy, rd_addr_valid, done and error outputs all 0 immediately; a new start completes cleanly with a full Depth sweep.
- Back-to-back: second start in the done cycle → second sweep begins the next cycle; error fields cleared, then reflect only the second sweep.
